// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator scan controller: enables one RO at a time, lets it settle,
// counts its edges over a fixed gate window and hands the count downstream.
module ro_scan_ctrl #(
  parameter int unsigned N_RO       = 8,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned GATE_CYC   = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              ro_edge,
  output logic [N_RO-1:0]   ro_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_id,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy,
  output logic              scan_done
);

  localparam int unsigned MAX_CYC = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC);
  localparam int unsigned IDX_W   = 4;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_RO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [N_RO-1:0]  EN_ONE      = N_RO'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_EMIT,
    S_NEXT
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [CNT_W-1:0]   counter, counter_d;
  logic [N_RO-1:0]    ro_en_d;
  logic               res_valid_d;
  logic [3:0]         res_id_d;
  logic [CNT_W-1:0]   res_count_d;
  logic               busy_d;
  logic               scan_done_d;

  // State, datapath and all outputs registered together from the next-state view
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      timer     <= '0;
      counter   <= '0;
      ro_en     <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_count <= '0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      timer     <= timer_d;
      counter   <= counter_d;
      ro_en     <= ro_en_d;
      res_valid <= res_valid_d;
      res_id    <= res_id_d;
      res_count <= res_count_d;
      busy      <= busy_d;
      scan_done <= scan_done_d;
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    timer_d     = timer;
    counter_d   = counter;
    res_valid_d = res_valid;
    res_id_d    = res_id;
    res_count_d = res_count;
    scan_done_d = 1'b0;
    ro_en_d     = '0;
    busy_d      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          timer_d = '0;
        end
      end

      S_SETTLE: begin
        if (timer == SETTLE_LAST) begin
          state_d   = S_GATE;
          timer_d   = '0;
          counter_d = '0;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end

      // The closing GATE cycle's edge is folded into the emitted count
      S_GATE: begin
        if (ro_edge && (counter != CNT_MAX)) begin
          counter_d = counter + CNT_W'(1);
        end
        if (timer == GATE_LAST) begin
          state_d     = S_EMIT;
          timer_d     = '0;
          res_valid_d = 1'b1;
          res_id_d    = idx;
          res_count_d = counter_d;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end

      S_EMIT: begin
        if (res_ready) begin
          state_d     = S_NEXT;
          res_valid_d = 1'b0;
          scan_done_d = (idx == IDX_LAST);
        end
      end

      S_NEXT: begin
        timer_d = '0;
        if (idx != IDX_LAST) begin
          idx_d   = idx + IDX_W'(1);
          state_d = S_SETTLE;
        end else if (cont) begin
          idx_d   = '0;
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d == S_SETTLE) || (state_d == S_GATE)) begin
      ro_en_d = EN_ONE << idx_d;
    end
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Directed bench for ro_scan_ctrl with a timed result scoreboard.
module tb_ro_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, cont_a = 1'b0, ro_edge_a = 1'b0, ready_a = 1'b1;
  logic [3:0]  ro_en_a;
  logic        valid_a, busy_a, done_a;
  logic [3:0]  res_id_a;
  logic [15:0] res_count_a;

  logic        start_b = 1'b0, cont_b = 1'b0, ro_edge_b = 1'b1, ready_b = 1'b1;
  logic [1:0]  ro_en_b;
  logic        valid_b, busy_b, done_b;
  logic [3:0]  res_id_b;
  logic [2:0]  res_count_b;

  typedef struct {
    int id;
    int cnt;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;
  int   cyc = 0, s_cyc = 0, mode = 0;
  int   done_cnt = 0, done_cyc = 0, nb = 0;
  int   hold_id, hold_cnt;

  ro_scan_ctrl #(.N_RO(4), .SETTLE_CYC(4), .GATE_CYC(10), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cont(cont_a), .ro_edge(ro_edge_a),
    .ro_en(ro_en_a), .res_valid(valid_a), .res_ready(ready_a), .res_id(res_id_a),
    .res_count(res_count_a), .busy(busy_a), .scan_done(done_a)
  );

  ro_scan_ctrl #(.N_RO(2), .SETTLE_CYC(2), .GATE_CYC(20), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cont(cont_b), .ro_edge(ro_edge_b),
    .ro_en(ro_en_b), .res_valid(valid_b), .res_ready(ready_b), .res_id(res_id_b),
    .res_count(res_count_b), .busy(busy_b), .scan_done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic edge_fn(input int m, input int k);
    case (m)
      0:       return ((k % 2) == 1);
      1:       return 1'b1;
      3:       return (k == 3) || (k == 13) || (k == 14);
      default: return 1'b0;
    endcase
  endfunction

  // Inputs change 2 time units after the falling edge
  task automatic tick();
    @(negedge clk);
    #2;
    ro_edge_a = edge_fn(mode, cyc - s_cyc - 1);
  endtask

  task automatic push_exp(input int first, input int n, input int c0, input int cr, input bit timed);
    for (int k = first; k < first + n; k++) begin
      exp_q.push_back('{id: k % 4, cnt: ((k % 4) == 0) ? c0 : cr,
                        cyc: timed ? (s_cyc + 15 + 16 * k) : -1});
    end
  endtask

  task automatic begin_scan(input int m, input int c0, input int cr, input bit timed);
    mode      = m;
    s_cyc     = cyc;
    start_a   = 1'b1;
    ro_edge_a = edge_fn(m, -1);
    push_exp(0, 4, c0, cr, timed);
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) break;
      tick();
    end
    chk(tag, int'(done_cnt >= target), 1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ro_en"}, int'(ro_en_a), 0);
    chk({tag, "_valid"}, int'(valid_a), 0);
    chk({tag, "_id"}, int'(res_id_a), 0);
    chk({tag, "_count"}, int'(res_count_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
  endtask

  // Scoreboard: results are compared when the handshake happens
  always @(negedge clk) begin
    #4;
    chk("a_onehot", int'($countones(ro_en_a) <= 1), 1);
    if (valid_a) chk("a_en_in_emit", int'(ro_en_a), 0);
    if (done_a) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (valid_a && ready_a) begin
      if (exp_q.size() == 0) begin
        chk("a_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("a_res_id", int'(res_id_a), e.id);
        chk("a_res_count", int'(res_count_a), e.cnt);
        if (e.cyc >= 0) chk("a_res_cycle", cyc, e.cyc);
      end
    end
    if (valid_b) begin
      chk("b_res_id", int'(res_id_b), nb);
      chk("b_res_count_sat", int'(res_count_b), 7);
      nb++;
    end
  end

  initial begin
    tick();
    tick();
    chk_zero_outputs("reset");

    // Start on the first edge after reset release; also kicks the saturation instance
    tick();
    rst     = 1'b1;
    start_b = 1'b1;
    begin_scan(0, 5, 5, 1'b1);
    start_b = 1'b0;
    chk("a_busy_scan", int'(busy_a), 1);
    chk("a_ro_en_first", int'(ro_en_a), 1);
    wait_done(1, 200, "a_done_seen");
    chk("a_done_latency", done_cyc - s_cyc, 64);
    tick();
    tick();
    chk("a_idle_busy", int'(busy_a), 0);
    chk("a_idle_ro_en", int'(ro_en_a), 0);

    // Start pulse during GATE must not disturb the scan
    tick();
    begin_scan(1, 10, 10, 1'b1);
    while (cyc < s_cyc + 9) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(2, 200, "b_done_seen");
    chk("b_done_latency", done_cyc - s_cyc, 64);

    // Edges in last SETTLE, last GATE and first EMIT cycle
    tick();
    tick();
    begin_scan(3, 1, 0, 1'b1);
    wait_done(3, 200, "c_done_seen");
    chk("c_done_latency", done_cyc - s_cyc, 64);

    // Back-pressure: hold the first result for 50 cycles
    tick();
    ready_a = 1'b0;
    begin_scan(0, 5, 5, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (valid_a) break;
      tick();
    end
    chk("d_valid_seen", int'(valid_a), 1);
    hold_id  = int'(res_id_a);
    hold_cnt = int'(res_count_a);
    chk("d_hold_id", hold_id, 0);
    chk("d_hold_count", hold_cnt, 5);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("d_stable", int'((valid_a === 1'b1) && (int'(res_id_a) == hold_id) &&
                           (int'(res_count_a) == hold_cnt) && (ro_en_a === 4'b0)), 1);
    end
    ready_a = 1'b1;
    tick();
    chk("d_valid_dropped", int'(valid_a), 0);
    wait_done(4, 200, "d_done_seen");

    // Continuous mode, cont dropped during RO 2 of the second scan
    tick();
    tick();
    cont_a = 1'b1;
    begin_scan(0, 5, 5, 1'b1);
    push_exp(4, 4, 5, 5, 1'b1);
    while (cyc < s_cyc + 102) tick();
    cont_a = 1'b0;
    wait_done(6, 300, "e_done_seen");
    chk("e_done_latency", done_cyc - s_cyc, 128);
    repeat (5) tick();
    chk("e_idle_busy", int'(busy_a), 0);
    chk("e_done_count", done_cnt, 6);

    // Reset during GATE of RO 1
    tick();
    begin_scan(0, 5, 5, 1'b1);
    while (cyc < s_cyc + 24) tick();
    chk("f_gate_ro_en", int'(ro_en_a), 2);
    rst = 1'b0;
    #1;
    chk_zero_outputs("f_async");
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("f_no_valid", int'(valid_a), 0);
    chk("f_no_busy", int'(busy_a), 0);
    begin_scan(0, 5, 5, 1'b1);
    wait_done(7, 200, "f_done_seen");
    chk("f_done_latency", done_cyc - s_cyc, 64);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("b_result_count", nb, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_scan_ctrl.md
RO_SCAN_CTRL -- requirements
Module: ro_scan_ctrl

Interface
REQ-001 Parameter N_RO, default 8: number of ring oscillators scanned, 2..16.
REQ-002 Parameter SETTLE_CYC, default 16: cycles an RO runs before counting starts, >=1.
REQ-003 Parameter GATE_CYC, default 1024: counting window length in clk cycles, >=2.
REQ-004 Parameter CNT_W, default 16: width of the per-RO edge count.
REQ-005 clk  in  1  single system clock; all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins one scan of RO 0..N_RO-1.
REQ-008 cont  in  1  when 1, a finished scan restarts at RO 0 without a new start.
REQ-009 ro_edge  in  1  one-cycle pulse per RO edge, already synchronized to clk.
REQ-010 ro_en  out  N_RO  one-hot enable of the RO under measurement; all-zero otherwise.
REQ-011 res_valid  out  1  result word available.
REQ-012 res_ready  in  1  downstream (UART framer) accepts the result when res_valid && res_ready.
REQ-013 res_id  out  4  index of the RO the result belongs to.
REQ-014 res_count  out  CNT_W  edge count for res_id.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 scan_done  out  1  one-cycle pulse after the last RO's result is accepted.

Function
REQ-017 FSM states: IDLE, SETTLE, GATE, EMIT, NEXT.
REQ-018 IDLE: ro_en=0, busy=0; start=1 -> SETTLE with idx=0, timer cleared.
REQ-019 SETTLE: ro_en[idx]=1; ro_edge ignored; after exactly SETTLE_CYC cycles -> GATE, counter cleared.
REQ-020 GATE: ro_en[idx]=1; each cycle with ro_edge=1 increments counter; lasts exactly GATE_CYC cycles, then -> EMIT.
REQ-021 Counter saturates at 2^CNT_W-1; no wrap.
REQ-022 An ro_edge in the final GATE cycle is counted; an ro_edge in the first EMIT cycle is not.
REQ-023 EMIT: ro_en=0; res_valid=1, res_id=idx, res_count=counter, all held stable until handshake.
REQ-024 EMIT handshake (res_ready=1) -> NEXT; res_valid falls the following cycle.
REQ-025 res_valid shall not depend combinationally on res_ready; res_ready may be high before res_valid.
REQ-026 NEXT (1 cycle): if idx<N_RO-1, idx+1 -> SETTLE; else pulse scan_done and -> SETTLE with idx=0 if cont=1, otherwise -> IDLE.
REQ-027 start while busy=1 is ignored.
REQ-028 cont sampled only in NEXT; deasserting cont mid-scan completes the current scan then idles.
REQ-029 Per-RO cycle count with res_ready tied high: SETTLE_CYC+GATE_CYC+2 cycles (EMIT 1, NEXT 1).
REQ-030 ro_en never has more than one bit set; it is low in EMIT, NEXT and IDLE so only one RO oscillates at a time.
REQ-031 All outputs registered.

Reset
REQ-032 On rst=0, asynchronously: state=IDLE, idx=0, counter=0, timers=0, ro_en=0, res_valid=0, res_id=0, res_count=0, busy=0, scan_done=0.
REQ-033 Reset mid-GATE or mid-EMIT discards the partial result; no res_valid after release until a new start.
REQ-034 First start is honoured on the first clk edge after rst deasserts.

Verification
REQ-035 N_RO=4, SETTLE_CYC=4, GATE_CYC=10, ro_edge every 2nd cycle, res_ready=1, start -> four results id 0..3, count=5 each, scan_done 1 cycle after id 3 accepted, 64 cycles start-to-done.
REQ-036 ro_edge constantly 1, CNT_W=3, GATE_CYC=20 -> res_count=7 (saturated).
REQ-037 res_ready held 0 for 50 cycles in EMIT -> res_valid, res_id, res_count stable throughout; ro_en=0; accepted on first ready cycle.
REQ-038 cont=1, then cont=0 during RO 2 of scan 2 -> scan 2 finishes through id N_RO-1, one scan_done, then IDLE, busy=0.
REQ-039 rst=0 during GATE of RO 1 -> all outputs zero immediately; after release no res_valid until start; new scan begins at id 0.
REQ-040 start pulsed during GATE -> ignored; result sequence and timing identical to the no-pulse run.
